systolic_feeder: RTL

SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

---
 rtl/systolic_feeder.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/systolic_feeder.sv
// Systolic array edge feeder: accepts one k-beat per cycle (an A column
// slice and a B row slice) and skews lane i of each by i+1 cycles behind a
// common capture stage, so the array's left and top edges see a diagonal
// wavefront. Each slot carries a data-valid bit and a last-beat marker. A
// small IDLE/FEED/DRAIN controller counts beats and holds off the next tile
// until the current one has fully left the chains.
module systolic_feeder #(
    parameter int  MAX_K = 256,
    localparam int KW    = $clog2(MAX_K + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0][31:0] in_a,
    input  logic [7:0][31:0] in_b,
    input  logic             in_last,
    output logic [7:0][31:0] aleft,
    output logic [7:0][31:0] bup,
    output logic [7:0]       enleft,
    output logic [7:0]       enup,
    output logic [7:0]       cmleft,
    output logic [7:0]       cmup,
    output logic             busy,
    output logic             tile_done,
    output logic [KW-1:0]    k_count,
    output logic             overflow
);

    typedef enum logic [1:0] {
        IDLE,
        FEED,
        DRAIN
    } state_t;

    state_t        state_q, state_d;
    logic [KW-1:0] kCount_q, kCount_d;
    logic          overflow_q, overflow_d;
    logic [2:0]    drainCnt_q, drainCnt_d;
    logic          ready_q, ready_d;
    logic          done_q, done_d;

    logic          accept;
    logic          beatCm;
    logic          atMax;

    // Valid and last-marker bits are identical for every lane apart from the
    // skew, so one shared 9-stage bit chain serves all A and B lanes.
    logic [8:0]    enPipe_q;
    logic [8:0]    cmPipe_q;

    assign accept = in_valid & ready_q;
    assign atMax  = (kCount_q == KW'(MAX_K));

    // Controller next-state: beat counting, overflow, and the 8-edge drain.
    always_comb begin
        state_d    = state_q;
        kCount_d   = kCount_q;
        overflow_d = overflow_q;
        drainCnt_d = drainCnt_q;
        done_d     = 1'b0;
        beatCm     = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    kCount_d = KW'(1);
                    beatCm   = in_last;
                    if (in_last) begin
                        state_d    = DRAIN;
                        drainCnt_d = 3'd7;
                    end else begin
                        state_d = FEED;
                    end
                end
            end
            FEED: begin
                if (accept) begin
                    beatCm = in_last | atMax;
                    if (atMax) begin
                        overflow_d = 1'b1;
                    end else begin
                        kCount_d = kCount_q + KW'(1);
                    end
                    if (in_last | atMax) begin
                        state_d    = DRAIN;
                        drainCnt_d = 3'd7;
                    end
                end
            end
            DRAIN: begin
                drainCnt_d = drainCnt_q - 3'd1;
                if (drainCnt_q == 3'd0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d != DRAIN);
    end

    // Controller registers; ready is registered so it stays low through reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            kCount_q   <= '0;
            overflow_q <= 1'b0;
            drainCnt_q <= '0;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            kCount_q   <= kCount_d;
            overflow_q <= overflow_d;
            drainCnt_q <= drainCnt_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
        end
    end

    // Shared valid/marker chain; idle edges inject a bubble at stage 0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            enPipe_q <= '0;
            cmPipe_q <= '0;
        end else begin
            enPipe_q <= {enPipe_q[7:0], accept};
            cmPipe_q <= {cmPipe_q[7:0], accept & beatCm};
        end
    end

    assign enleft = enPipe_q[8:1];
    assign enup   = enPipe_q[8:1];
    assign cmleft = cmPipe_q[8:1];
    assign cmup   = cmPipe_q[8:1];

    // Per-lane data chains, depth grows with lane index to form the skew.
    for (genvar i = 0; i < 8; i++) begin : gLane
        logic [31:0] aChain_q [i+2];
        logic [31:0] bChain_q [i+2];

        // Capture stage plus i+1 skew stages; bubbles carry zero data.
        always_ff @(posedge clk) begin
            if (!rst) begin
                for (int k = 0; k < i + 2; k++) begin
                    aChain_q[k] <= '0;
                    bChain_q[k] <= '0;
                end
            end else begin
                aChain_q[0] <= accept ? in_a[i] : '0;
                bChain_q[0] <= accept ? in_b[i] : '0;
                for (int k = 1; k < i + 2; k++) begin
                    aChain_q[k] <= aChain_q[k-1];
                    bChain_q[k] <= bChain_q[k-1];
                end
            end
        end

        assign aleft[i] = aChain_q[i+1];
        assign bup[i]   = bChain_q[i+1];
    end

    assign in_ready  = ready_q;
    assign tile_done = done_q;
    assign busy      = (state_q != IDLE) | done_q;
    assign k_count   = kCount_q;
    assign overflow  = overflow_q;

endmodule
